memory_stage: RTL and testbench
===============================

MEMORY_STAGE -- requirements
Module: memory_stage
Interface
REQ-001 N, 64, datapath/address width in bits.
REQ-002 TIMEOUT, 16, max cycles dm_req is held awaiting dm_ack (>=2).
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high.
REQ-005 in_valid  in  1  execute results valid this cycle.
REQ-006 in_ready  out  1  stage accepts inputs this cycle.
REQ-007 aluResult_E  in  N  ALU result / memory byte address.
REQ-008 writeData_E  in  N  store data.
REQ-009 PCBranch_E  in  N  branch target.
REQ-010 zero_E  in  1  ALU zero flag.
REQ-011 Branch_E  in  1  instruction is conditional branch.
REQ-012 MemRead_E  in  1  load.
REQ-013 MemWrite_E  in  1  store.
REQ-014 dm_req  out  1  data-memory request.
REQ-015 dm_we  out  1  request is write.
REQ-016 dm_addr  out  N  request address.
REQ-017 dm_wdata  out  N  write data.
REQ-018 dm_ack  in  1  memory completes request this cycle.
REQ-019 dm_rdata  in  N  read data, valid with dm_ack.
REQ-020 out_valid  out  1  one-cycle pulse: registered results valid.
REQ-021 aluResult_M  out  N  captured ALU result.
REQ-022 readData_M  out  N  load data; 0 for non-loads.
REQ-023 PCBranch_M  out  N  captured branch target.
REQ-024 PCSrc_M  out  1  branch taken; = out_valid & Branch & zero (captured).
REQ-025 err_M  out  1  misaligned access or timeout; valid with out_valid.
Function
REQ-026 FSM states IDLE, ACCESS, RESP; in_ready=1 only in IDLE.
REQ-027 IDLE & in_valid: capture all *_E inputs into registers, clear readData_M and err_M to 0.
REQ-028 Accept with MemRead_E|MemWrite_E and aluResult_E[2:0]==0 -> ACCESS; MemWrite_E has priority when both set (dm_we=1).
REQ-029 Accept with memory op and aluResult_E[2:0]!=0 -> RESP, err_M=1, no dm_req issued.
REQ-030 Accept with no memory op -> RESP; out_valid asserted the cycle after acceptance.
REQ-031 ACCESS: dm_req=1; dm_addr, dm_we, dm_wdata driven from captured registers, stable until exit.
REQ-032 ACCESS & dm_ack: load -> readData_M<=dm_rdata; -> RESP; dm_req low from next cycle.
REQ-033 Cycle counter cleared on ACCESS entry, +1 per ACCESS cycle without ack; no ack with counter==TIMEOUT-1 -> RESP, err_M=1.
REQ-034 dm_ack in same cycle as the timeout condition wins: normal completion, err_M=0.
REQ-035 RESP lasts exactly one cycle: out_valid=1, then IDLE; in_valid during RESP is not accepted.
REQ-036 dm_ack outside ACCESS ignored; dm_req never asserted outside ACCESS.
REQ-037 Latency: non-mem/misaligned 1 cycle accept->out_valid; mem op = ack cycle +1; throughput max 1 op / 2 cycles.
REQ-038 aluResult_M, PCBranch_M, readData_M, err_M hold value until next acceptance; PCSrc_M=0 whenever out_valid=0.
Reset
REQ-039 reset at edge: state IDLE, counter 0, all registered outputs 0, out_valid=0, dm_req=0, in_ready=1; overrides all other events.
REQ-040 reset mid-ACCESS abandons transaction: dm_req=0 next cycle, no out_valid, late dm_ack ignored.
Verification
REQ-041 ALU op: in_valid, Branch=1, zero=1, PCBranch_E=0x40 -> next cycle out_valid=1, PCSrc_M=1, PCBranch_M=0x40, dm_req never 1.
REQ-042 Load addr 0x100, ack 3 cycles later with rdata 0xDEAD -> dm_req 3 cycles, readData_M=0xDEAD, err_M=0, out_valid the cycle after ack.
REQ-043 Store addr 0x104 -> no dm_req, out_valid next cycle, err_M=1; store 0x108 data 0x55 -> dm_we=1, dm_wdata=0x55 until ack.
REQ-044 Load, no ack -> dm_req exactly 16 cycles, then out_valid, err_M=1; ack on 16th cycle instead -> err_M=0.
REQ-045 Reset during ACCESS cycle 2, then ack -> no out_valid, in_ready=1, outputs 0; new op accepted normally.

Source files
------------

// File: rtl/memory_stage.sv
// memory_stage: memory pipeline stage between execute and writeback.
// Captures execute results, issues one data-memory request for aligned
// loads/stores and waits for the ack (bounded by TIMEOUT cycles). It then
// presents the registered results with a one-cycle out_valid pulse.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | ready for a new op (in_ready=1)
// ACCESS | dm_req held from captured registers, waiting for dm_ack
// RESP   | results valid for exactly one cycle (out_valid=1)
//
// Ports:
//   clk, reset                       clock, synchronous active-high reset
//   in_valid / in_ready              execute handshake
//   aluResult_E, writeData_E,
//   PCBranch_E, zero_E, Branch_E,
//   MemRead_E, MemWrite_E            execute-stage results
//   dm_req, dm_we, dm_addr, dm_wdata data-memory request
//   dm_ack, dm_rdata                 data-memory completion / read data
//   out_valid, aluResult_M,
//   readData_M, PCBranch_M,
//   PCSrc_M, err_M                   memory-stage results
module memory_stage #(
  parameter int N       = 64,
  parameter int TIMEOUT = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] aluResult_E,
  input  logic [N-1:0] writeData_E,
  input  logic [N-1:0] PCBranch_E,
  input  logic         zero_E,
  input  logic         Branch_E,
  input  logic         MemRead_E,
  input  logic         MemWrite_E,
  output logic         dm_req,
  output logic         dm_we,
  output logic [N-1:0] dm_addr,
  output logic [N-1:0] dm_wdata,
  input  logic         dm_ack,
  input  logic [N-1:0] dm_rdata,
  output logic         out_valid,
  output logic [N-1:0] aluResult_M,
  output logic [N-1:0] readData_M,
  output logic [N-1:0] PCBranch_M,
  output logic         PCSrc_M,
  output logic         err_M
);

  localparam int CW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t         state;
  logic [N-1:0]   wdata_q;
  logic           zero_q;
  logic           branch_q;
  logic           read_q;
  logic           write_q;
  logic [CW-1:0]  cnt;
  logic           mem_op_e;
  logic           aligned_e;

  assign mem_op_e  = MemRead_E | MemWrite_E;
  assign aligned_e = (aluResult_E[2:0] == 3'b000);

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      wdata_q     <= '0;
      zero_q      <= 1'b0;
      branch_q    <= 1'b0;
      read_q      <= 1'b0;
      write_q     <= 1'b0;
      aluResult_M <= '0;
      readData_M  <= '0;
      PCBranch_M  <= '0;
      err_M       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            aluResult_M <= aluResult_E;
            wdata_q     <= writeData_E;
            PCBranch_M  <= PCBranch_E;
            zero_q      <= zero_E;
            branch_q    <= Branch_E;
            read_q      <= MemRead_E;
            write_q     <= MemWrite_E;
            readData_M  <= '0;
            cnt         <= '0;
            if (mem_op_e && aligned_e) begin
              err_M <= 1'b0;
              state <= ACCESS;
            end else begin
              // misaligned memory ops complete immediately with an error
              err_M <= mem_op_e;
              state <= RESP;
            end
          end
        end
        ACCESS: begin
          // an ack arriving in the timeout cycle still counts as completion
          if (dm_ack) begin
            if (read_q && !write_q) readData_M <= dm_rdata;
            state <= RESP;
          end else if (cnt == CW'(TIMEOUT - 1)) begin
            err_M <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign dm_req    = (state == ACCESS);
  // a store wins when both MemRead and MemWrite were set
  assign dm_we     = dm_req & write_q;
  assign dm_addr   = aluResult_M;
  assign dm_wdata  = wdata_q;
  assign out_valid = (state == RESP);
  assign PCSrc_M   = out_valid & branch_q & zero_q;

endmodule

// File: tb/tb_memory_stage.sv
module tb_memory_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] aluResult_E, writeData_E, PCBranch_E;
  logic        zero_E, Branch_E, MemRead_E, MemWrite_E;
  logic        dm_req, dm_we;
  logic [63:0] dm_addr, dm_wdata;
  logic        dm_ack;
  logic [63:0] dm_rdata;
  logic        out_valid;
  logic [63:0] aluResult_M, readData_M, PCBranch_M;
  logic        PCSrc_M, err_M;

  int checks = 0;
  int errors = 0;

  memory_stage #(.N(64), .TIMEOUT(16)) dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .aluResult_E(aluResult_E), .writeData_E(writeData_E), .PCBranch_E(PCBranch_E),
    .zero_E(zero_E), .Branch_E(Branch_E), .MemRead_E(MemRead_E), .MemWrite_E(MemWrite_E),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_ack(dm_ack), .dm_rdata(dm_rdata),
    .out_valid(out_valid), .aluResult_M(aluResult_M), .readData_M(readData_M),
    .PCBranch_M(PCBranch_M), .PCSrc_M(PCSrc_M), .err_M(err_M)
  );

  always #5 clk = ~clk;

  // advance one rising edge, then settle past it
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; aluResult_E = 0; writeData_E = 0; PCBranch_E = 0;
    zero_E = 0; Branch_E = 0; MemRead_E = 0; MemWrite_E = 0;
    dm_ack = 0; dm_rdata = 0;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    step(); step();
    reset = 0;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    checks++; if (dm_req !== 1'b0) begin errors++; $display("FAIL reset_dm_req: got %b expected 0", dm_req); end
    checks++; if ({aluResult_M, readData_M, PCBranch_M} !== 192'd0) begin errors++; $display("FAIL reset_regs: got %h %h %h expected 0", aluResult_M, readData_M, PCBranch_M); end
    checks++; if ({err_M, PCSrc_M} !== 2'b00) begin errors++; $display("FAIL reset_flags: got %b expected 00", {err_M, PCSrc_M}); end
  endtask

  task automatic test_alu_branch();
    in_valid = 1; Branch_E = 1; zero_E = 1; PCBranch_E = 64'h40; aluResult_E = 64'h7;
    step();
    clear_inputs();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL alu_out_valid: got %b expected 1", out_valid); end
    checks++; if (PCSrc_M !== 1'b1) begin errors++; $display("FAIL alu_pcsrc: got %b expected 1", PCSrc_M); end
    checks++; if (PCBranch_M !== 64'h40) begin errors++; $display("FAIL alu_pcbranch: got %h expected 40", PCBranch_M); end
    checks++; if (aluResult_M !== 64'h7) begin errors++; $display("FAIL alu_result: got %h expected 7", aluResult_M); end
    checks++; if ({dm_req, err_M, in_ready} !== 3'b000) begin errors++; $display("FAIL alu_req_err_ready: got %b expected 000", {dm_req, err_M, in_ready}); end
    step();
    checks++; if ({out_valid, PCSrc_M, in_ready, dm_req} !== 4'b0010) begin errors++; $display("FAIL alu_after: got %b expected 0010", {out_valid, PCSrc_M, in_ready, dm_req}); end
    checks++; if (PCBranch_M !== 64'h40) begin errors++; $display("FAIL alu_hold: got %h expected 40", PCBranch_M); end
  endtask

  task automatic test_load();
    int req_cycles = 0;
    in_valid = 1; MemRead_E = 1; aluResult_E = 64'h100;
    step();
    clear_inputs();
    for (int i = 0; i < 3; i++) begin
      if (dm_req === 1'b1) req_cycles++;
      checks++; if (dm_addr !== 64'h100 || dm_we !== 1'b0) begin errors++; $display("FAIL load_req_fields: got addr %h we %b expected 100 0", dm_addr, dm_we); end
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL load_early_valid: got %b expected 0", out_valid); end
      if (i == 2) begin dm_ack = 1; dm_rdata = 64'hDEAD; end
      step();
    end
    dm_ack = 0; dm_rdata = 0;
    checks++; if (req_cycles != 3) begin errors++; $display("FAIL load_req_cycles: got %0d expected 3", req_cycles); end
    checks++; if ({out_valid, dm_req, err_M} !== 3'b100) begin errors++; $display("FAIL load_resp_flags: got %b expected 100", {out_valid, dm_req, err_M}); end
    checks++; if (readData_M !== 64'hDEAD) begin errors++; $display("FAIL load_rdata: got %h expected dead", readData_M); end
    // ack outside ACCESS must not disturb held results
    dm_ack = 1; dm_rdata = 64'h1234;
    step();
    dm_ack = 0; dm_rdata = 0;
    checks++; if ({out_valid, dm_req} !== 2'b00 || readData_M !== 64'hDEAD) begin errors++; $display("FAIL load_hold: got valid/req %b rdata %h expected 00 dead", {out_valid, dm_req}, readData_M); end
  endtask

  task automatic test_misaligned();
    in_valid = 1; MemWrite_E = 1; aluResult_E = 64'h104; writeData_E = 64'h99;
    step();
    clear_inputs();
    checks++; if ({out_valid, err_M, dm_req} !== 3'b110) begin errors++; $display("FAIL misaligned: got valid/err/req %b expected 110", {out_valid, err_M, dm_req}); end
    checks++; if (readData_M !== 64'h0) begin errors++; $display("FAIL misaligned_rdata_clear: got %h expected 0", readData_M); end
    step();
    checks++; if ({in_ready, err_M} !== 2'b11) begin errors++; $display("FAIL misaligned_hold: got ready/err %b expected 11", {in_ready, err_M}); end
  endtask

  task automatic test_store();
    in_valid = 1; MemWrite_E = 1; aluResult_E = 64'h108; writeData_E = 64'h55;
    step();
    clear_inputs();
    for (int i = 0; i < 2; i++) begin
      checks++; if ({dm_req, dm_we} !== 2'b11 || dm_wdata !== 64'h55 || dm_addr !== 64'h108) begin errors++; $display("FAIL store_req: got req/we %b wdata %h addr %h expected 11 55 108", {dm_req, dm_we}, dm_wdata, dm_addr); end
      if (i == 1) begin dm_ack = 1; dm_rdata = 64'hFFFF; end
      step();
    end
    dm_ack = 0; dm_rdata = 0;
    checks++; if ({out_valid, err_M, dm_req} !== 3'b100 || readData_M !== 64'h0) begin errors++; $display("FAIL store_resp: got valid/err/req %b rdata %h expected 100 0", {out_valid, err_M, dm_req}, readData_M); end
    step();
  endtask

  task automatic test_rw_priority();
    in_valid = 1; MemWrite_E = 1; MemRead_E = 1; aluResult_E = 64'h110; writeData_E = 64'hAB;
    step();
    clear_inputs();
    checks++; if ({dm_req, dm_we} !== 2'b11) begin errors++; $display("FAIL rw_we: got %b expected 11", {dm_req, dm_we}); end
    dm_ack = 1; dm_rdata = 64'hCAFE;
    step();
    dm_ack = 0; dm_rdata = 0;
    checks++; if (out_valid !== 1'b1 || readData_M !== 64'h0) begin errors++; $display("FAIL rw_rdata: got valid %b rdata %h expected 1 0", out_valid, readData_M); end
    step();
  endtask

  task automatic test_timeout();
    int req_cycles = 0;
    bit seen = 0;
    in_valid = 1; MemRead_E = 1; aluResult_E = 64'h200;
    step();
    clear_inputs();
    for (int i = 0; i < 40 && !seen; i++) begin
      if (out_valid === 1'b1) seen = 1;
      else begin
        if (dm_req === 1'b1) req_cycles++;
        step();
      end
    end
    checks++; if (!seen) begin errors++; $display("FAIL timeout_no_valid: got no out_valid within 40 cycles expected one"); end
    checks++; if (req_cycles != 16) begin errors++; $display("FAIL timeout_req_cycles: got %0d expected 16", req_cycles); end
    checks++; if ({err_M, dm_req} !== 2'b10 || readData_M !== 64'h0) begin errors++; $display("FAIL timeout_err: got err/req %b rdata %h expected 10 0", {err_M, dm_req}, readData_M); end
    step();
    // ack in the 16th ACCESS cycle beats the timeout
    in_valid = 1; MemRead_E = 1; aluResult_E = 64'h208;
    step();
    clear_inputs();
    repeat (15) step();
    checks++; if ({dm_req, out_valid} !== 2'b10) begin errors++; $display("FAIL late_ack_still_req: got %b expected 10", {dm_req, out_valid}); end
    dm_ack = 1; dm_rdata = 64'hBEEF;
    step();
    dm_ack = 0; dm_rdata = 0;
    checks++; if ({out_valid, err_M} !== 2'b10 || readData_M !== 64'hBEEF) begin errors++; $display("FAIL late_ack_resp: got valid/err %b rdata %h expected 10 beef", {out_valid, err_M}, readData_M); end
    step();
  endtask

  task automatic test_back_to_back();
    in_valid = 1; aluResult_E = 64'h11;
    step();
    checks++; if (out_valid !== 1'b1 || aluResult_M !== 64'h11) begin errors++; $display("FAIL b2b_first: got valid %b alu %h expected 1 11", out_valid, aluResult_M); end
    aluResult_E = 64'h22;
    step();
    checks++; if ({out_valid, in_ready} !== 2'b01 || aluResult_M !== 64'h11) begin errors++; $display("FAIL b2b_resp_block: got valid/ready %b alu %h expected 01 11", {out_valid, in_ready}, aluResult_M); end
    step();
    clear_inputs();
    checks++; if (out_valid !== 1'b1 || aluResult_M !== 64'h22) begin errors++; $display("FAIL b2b_second: got valid %b alu %h expected 1 22", out_valid, aluResult_M); end
    step();
  endtask

  task automatic test_reset_mid_access();
    bit bad_valid = 0;
    in_valid = 1; MemRead_E = 1; aluResult_E = 64'h300; PCBranch_E = 64'h80;
    step();
    clear_inputs();
    step();
    checks++; if (dm_req !== 1'b1) begin errors++; $display("FAIL rst_mid_req_before: got %b expected 1", dm_req); end
    reset = 1;
    step();
    reset = 0;
    checks++; if ({dm_req, out_valid, in_ready} !== 3'b001) begin errors++; $display("FAIL rst_mid_state: got req/valid/ready %b expected 001", {dm_req, out_valid, in_ready}); end
    checks++; if ({aluResult_M, PCBranch_M, readData_M} !== 192'd0 || err_M !== 1'b0) begin errors++; $display("FAIL rst_mid_regs: got %h %h %h err %b expected zeros", aluResult_M, PCBranch_M, readData_M, err_M); end
    dm_ack = 1; dm_rdata = 64'hAAAA;
    for (int i = 0; i < 3; i++) begin
      step();
      dm_ack = 0; dm_rdata = 0;
      if (out_valid !== 1'b0 || dm_req !== 1'b0) bad_valid = 1;
    end
    checks++; if (bad_valid || readData_M !== 64'h0) begin errors++; $display("FAIL rst_mid_late_ack: got stray valid/req %b rdata %h expected 0 0", bad_valid, readData_M); end
    in_valid = 1; aluResult_E = 64'h5;
    step();
    clear_inputs();
    checks++; if (out_valid !== 1'b1 || aluResult_M !== 64'h5) begin errors++; $display("FAIL rst_mid_new_op: got valid %b alu %h expected 1 5", out_valid, aluResult_M); end
    step();
  endtask

  initial begin
    test_reset();
    test_alu_branch();
    test_load();
    test_misaligned();
    test_store();
    test_rw_priority();
    test_timeout();
    test_back_to_back();
    test_reset_mid_access();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
